// File: rtl/timer_pkg.sv
// Shared definitions for the timer / trigger slice: trigger FSM states and
// the counter width used by pulse_timer.
package timer_pkg;

    // Counter width of the upstream pulse_timer, kept here so both blocks agree.
    localparam int TIMER_CNT_WIDTH = 16;

    // Trigger FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        PENDING = 2'd2
    } trig_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Increment on request until the all-ones ceiling; clear has priority.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/tick_trigger.sv
// Divides the pulse_timer tick by a live ratio and presents each resulting
// trigger over valid/ready. Triggers arriving while one is still pending are
// coalesced and counted as overruns.
module tick_trigger
    import timer_pkg::*;
#(
    parameter int DIV_WIDTH = 8,
    parameter int SEQ_WIDTH = 16,
    parameter int OVR_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick_in,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 trig_valid,
    input  logic                 trig_ready,
    output logic [SEQ_WIDTH-1:0] trig_seq,
    output logic [OVR_WIDTH-1:0] overrun_count,
    output logic                 busy
);

    logic [DIV_WIDTH-1:0] tick_cnt;
    logic [DIV_WIDTH-1:0] div_eff;
    logic                 fire;
    logic                 transfer;
    logic                 ovr_inc;

    trig_state_t          state;
    trig_state_t          state_next;
    logic                 valid_next;
    logic [SEQ_WIDTH-1:0] seq_next;

    // A divide ratio of zero behaves as one; div is compared live on every tick.
    assign div_eff  = (div == '0) ? DIV_WIDTH'(1) : div;
    // Using >= means lowering div below the current count fires on the next tick.
    assign fire     = tick_in && enable && (tick_cnt >= (div_eff - DIV_WIDTH'(1)));
    assign transfer = trig_valid && trig_ready;
    assign busy     = enable || trig_valid;

    // Tick counter: restarts on every fire and is held at zero while disabled.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            tick_cnt <= '0;
        end else if (tick_in) begin
            tick_cnt <= fire ? '0 : tick_cnt + DIV_WIDTH'(1);
        end
    end

    // State, valid and sequence registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            trig_valid <= 1'b0;
            trig_seq   <= '0;
        end else begin
            state      <= state_next;
            trig_valid <= valid_next;
            trig_seq   <= seq_next;
        end
    end

    // Next-state logic: raise triggers, retire them on transfer, flag overruns.
    always_comb begin
        state_next = state;
        valid_next = trig_valid;
        seq_next   = trig_seq;
        ovr_inc    = 1'b0;
        case (state)
            IDLE: begin
                // A fire on the very cycle enable rises is not dropped.
                if (fire) begin
                    state_next = PENDING;
                    valid_next = 1'b1;
                end else if (enable) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (fire) begin
                    state_next = PENDING;
                    valid_next = 1'b1;
                end else if (!enable) begin
                    state_next = IDLE;
                end
            end
            PENDING: begin
                if (transfer) begin
                    seq_next = trig_seq + SEQ_WIDTH'(1);
                    if (!fire) begin
                        valid_next = 1'b0;
                        state_next = enable ? ARMED : IDLE;
                    end
                end else if (fire) begin
                    ovr_inc = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
            end
        endcase
    end

    sat_counter #(
        .WIDTH (OVR_WIDTH)
    ) u_overrun (
        .clk   (clk),
        .clear (reset),
        .inc   (ovr_inc),
        .count (overrun_count)
    );

endmodule

// File: tb/tb_tick_trigger.sv
// Directed bench for tick_trigger with hand-computed expectations.
module tb_tick_trigger;
    import timer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick_in;
    logic        enable;
    logic [7:0]  div;
    logic        trig_valid;
    logic        trig_ready;
    logic [15:0] trig_seq;
    logic [7:0]  overrun_count;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int gaps;

    tick_trigger #(
        .DIV_WIDTH (8),
        .SEQ_WIDTH (16),
        .OVR_WIDTH (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .tick_in       (tick_in),
        .enable        (enable),
        .div           (div),
        .trig_valid    (trig_valid),
        .trig_ready    (trig_ready),
        .trig_seq      (trig_seq),
        .overrun_count (overrun_count),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        enable     = 1'b0;
        tick_in    = 1'b0;
        trig_ready = 1'b0;
        div        = 8'd0;
        cyc();
        reset      = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; tick_in = 1'b0; trig_ready = 1'b0; div = 8'd0;
        cyc(); cyc();
        chk("rst_valid", 32'(trig_valid), 32'd0);
        chk("rst_seq",   32'(trig_seq), 32'd0);
        chk("rst_ovr",   32'(overrun_count), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        reset = 1'b0;

        // div=3, ready held high, 9 ticks
        div = 8'd3; trig_ready = 1'b1; enable = 1'b1;
        cyc();
        for (int k = 1; k <= 9; k++) begin
            tick_in = 1'b1; cyc(); tick_in = 1'b0;
            chk("t1_valid", 32'(trig_valid), 32'((k % 3) == 0));
            if ((k % 3) == 0) chk("t1_seq", 32'(trig_seq), 32'(k / 3 - 1));
            cyc();
            chk("t1_drop", 32'(trig_valid), 32'd0);
        end
        chk("t1_seq_end", 32'(trig_seq), 32'd3);
        chk("t1_ovr", 32'(overrun_count), 32'd0);

        // div=0 treated as 1, ready low, 5 ticks
        do_reset();
        enable = 1'b1; div = 8'd0; cyc();
        tick_in = 1'b1; cyc();
        chk("t2_first", 32'(trig_valid), 32'd1);
        repeat (4) cyc();
        tick_in = 1'b0;
        chk("t2_valid", 32'(trig_valid), 32'd1);
        chk("t2_seq0", 32'(trig_seq), 32'd0);
        chk("t2_ovr", 32'(overrun_count), 32'd4);
        trig_ready = 1'b1; cyc(); trig_ready = 1'b0;
        chk("t2_seq1", 32'(trig_seq), 32'd1);
        chk("t2_drop", 32'(trig_valid), 32'd0);
        cyc();
        chk("t2_ovr_hold", 32'(overrun_count), 32'd4);

        // overrun saturation at 255
        do_reset();
        enable = 1'b1; cyc();
        div = 8'd1; tick_in = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            cyc();
            if (i == 255) chk("t4_ovr254", 32'(overrun_count), 32'd254);
            if (i == 256) chk("t4_ovr255", 32'(overrun_count), 32'd255);
        end
        tick_in = 1'b0;
        chk("t4_ovr_sat", 32'(overrun_count), 32'd255);
        chk("t4_valid", 32'(trig_valid), 32'd1);
        chk("t4_seq", 32'(trig_seq), 32'd0);

        // enable drops while pending
        do_reset();
        enable = 1'b1; div = 8'd2; cyc();
        tick_in = 1'b1; cyc(); cyc(); tick_in = 1'b0;
        chk("t5_fire", 32'(trig_valid), 32'd1);
        tick_in = 1'b1; cyc(); tick_in = 1'b0;       // tick_cnt now 1
        enable = 1'b0; cyc();
        chk("t5_hold", 32'(trig_valid), 32'd1);
        chk("t5_busy", 32'(busy), 32'd1);
        tick_in = 1'b1; repeat (3) cyc(); tick_in = 1'b0;
        chk("t5_nofire", 32'(overrun_count), 32'd0);
        trig_ready = 1'b1; cyc(); trig_ready = 1'b0;
        chk("t5_xfer_valid", 32'(trig_valid), 32'd0);
        chk("t5_xfer_seq", 32'(trig_seq), 32'd1);
        chk("t5_busy_low", 32'(busy), 32'd0);
        enable = 1'b1; cyc();
        tick_in = 1'b1; cyc(); tick_in = 1'b0;
        chk("t5_tick1", 32'(trig_valid), 32'd0);
        tick_in = 1'b1; cyc(); tick_in = 1'b0;
        chk("t5_tick2", 32'(trig_valid), 32'd1);

        // lowering div below the current count fires on the next tick
        do_reset();
        enable = 1'b1; div = 8'd4; trig_ready = 1'b1; cyc();
        tick_in = 1'b1; repeat (3) cyc(); tick_in = 1'b0;
        chk("t7_nofire", 32'(trig_valid), 32'd0);
        div = 8'd2;
        tick_in = 1'b1; cyc(); tick_in = 1'b0;
        chk("t7_fire", 32'(trig_valid), 32'd1);

        // reset while pending with three overruns
        do_reset();
        enable = 1'b1; cyc();
        div = 8'd1; tick_in = 1'b1; repeat (4) cyc(); tick_in = 1'b0;
        chk("t6_ovr3", 32'(overrun_count), 32'd3);
        chk("t6_pend", 32'(trig_valid), 32'd1);
        reset = 1'b1; enable = 1'b0; cyc(); reset = 1'b0;
        chk("t6_valid", 32'(trig_valid), 32'd0);
        chk("t6_seq", 32'(trig_seq), 32'd0);
        chk("t6_ovr", 32'(overrun_count), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_state", 32'(dut.state), 32'(IDLE));

        // fire and transfer every cycle, sequence wraps
        do_reset();
        enable = 1'b1; cyc();
        div = 8'd1; trig_ready = 1'b1; tick_in = 1'b1;
        gaps = 0;
        for (int k = 1; k <= 65537; k++) begin
            cyc();
            if (!trig_valid) gaps++;
            if (k == 1)     chk("t3_seq0", 32'(trig_seq), 32'd0);
            if (k == 2)     chk("t3_seq1", 32'(trig_seq), 32'd1);
            if (k == 65536) chk("t3_seqffff", 32'(trig_seq), 32'h0000ffff);
            if (k == 65537) chk("t3_wrap", 32'(trig_seq), 32'd0);
        end
        tick_in = 1'b0; trig_ready = 1'b0;
        chk("t3_gaps", 32'(gaps), 32'd0);
        chk("t3_ovr", 32'(overrun_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tick_trigger.md
# tick_trigger

Tick-driven trigger generator that sits directly downstream of `pulse_timer`. It consumes the single-cycle periodic pulse, divides it by a runtime-programmable ratio, and presents each resulting trigger to a consumer over a valid/ready handshake. Triggers the consumer cannot take in time are coalesced and counted as overruns. Typical consumers are periodic sampling, heartbeat LEDs and status-report engines.

## Interface
Parameters:
- `DIV_WIDTH`, default 8: width of the tick divide ratio.
- `SEQ_WIDTH`, default 16: width of the trigger sequence number.
- `OVR_WIDTH`, default 8: width of the saturating overrun counter.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high reset.
- `tick_in`, in, 1: single-cycle pulse from the upstream timer (same clock domain).
- `enable`, in, 1: level; allows tick counting and trigger generation.
- `div`, in, DIV_WIDTH: ticks per trigger. 0 is treated as 1.
- `trig_valid`, out, 1: a trigger is pending.
- `trig_ready`, in, 1: consumer accepts the trigger.
- `trig_seq`, out, SEQ_WIDTH: sequence number of the presented trigger.
- `overrun_count`, out, OVR_WIDTH: triggers coalesced while pending; saturating.
- `busy`, out, 1: `enable` is high or `trig_valid` is high.

## Operation
- `div_eff` = (`div` == 0) ? 1 : `div`. The live value is compared on every tick; there is no latching.
- Tick counter `tick_cnt` (DIV_WIDTH bits):
  - On `tick_in` with `enable`=1: if `tick_cnt` >= `div_eff`-1, a *fire* event occurs and `tick_cnt` <= 0. Otherwise `tick_cnt` <= `tick_cnt`+1.
  - `enable`=0 forces `tick_cnt` <= 0 and blocks fire events.
  - Lowering `div` below the current count makes the next tick fire.
- Handshake: transfer happens when `trig_valid` && `trig_ready`.
  - Once asserted, `trig_valid` stays high until a transfer, even if `enable` drops.
  - `trig_seq` is stable while `trig_valid` is high.
- State machine, states IDLE, ARMED, PENDING:
  - IDLE (`enable`=0, no trigger): goes to ARMED when `enable` rises.
  - ARMED: on fire, `trig_valid` <= 1 and go to PENDING. If `enable` falls, go to IDLE.
  - PENDING, transfer without fire: `trig_seq` <= `trig_seq`+1, `trig_valid` <= 0, next state ARMED if `enable` else IDLE.
  - PENDING, fire without transfer: the trigger is coalesced and `overrun_count` <= min(`overrun_count`+1, 2^OVR_WIDTH-1).
  - PENDING, fire and transfer in the same cycle: `trig_seq` increments, `trig_valid` stays 1 (the new trigger is presented), state stays PENDING, no overrun.
- `trig_seq` wraps modulo 2^SEQ_WIDTH.
- `overrun_count` clears only on reset.
- Reset mid-operation: everything returns to reset values immediately, and any pending trigger is dropped.

## Timing
- Reset values: `trig_valid`=0, `trig_seq`=0, `overrun_count`=0, `busy`=0, `tick_cnt`=0, state IDLE.
- Latency: `tick_in` sampled at edge N causes `trig_valid`=1 after edge N, i.e. visible in cycle N+1. `trig_valid` is registered.
- After a transfer at edge N, `trig_valid` is low from cycle N+1 unless a fire occurs at the same edge.
- `trig_ready` may be held high permanently. In that case each fire yields exactly one single-cycle `trig_valid` and no overruns.
- `busy` is combinational from `enable` and registered `trig_valid`. All other outputs are registered.
- `tick_in` high for consecutive cycles counts as one tick per cycle; there is no edge detection.

## Structure
- Shared package `timer_pkg` holds:
  - the state enum `trig_state_t` (IDLE, ARMED, PENDING);
  - a width constant shared with `pulse_timer`'s counter width.
- One sub-module, `sat_counter`: a parameterised width, saturating increment with synchronous clear, used for `overrun_count`.
- The rest is a single flat always block plus the state register.

## Test plan
- `div`=3, `trig_ready`=1, 9 ticks: 3 triggers with `trig_seq` 0, 1, 2, each one cycle long; `trig_valid` rises the cycle after ticks 3, 6 and 9; `overrun_count`=0.
- `div`=0, `trig_ready`=0, 5 ticks: `trig_valid` rises after the first tick and stays high; `overrun_count`=4; after `trig_ready` pulses, `trig_seq`=1 and `trig_valid`=0.
- Fire and transfer at the same edge (`div`=1, ticks every cycle, `trig_ready`=1): `trig_valid` stays continuously high and `trig_seq` increments every cycle; `trig_seq` wraps from 0xFFFF to 0 with `SEQ_WIDTH`=16.
- `trig_ready`=0, 300 ticks with `div`=1, `OVR_WIDTH`=8: `overrun_count` saturates at 255.
- `enable` drops while PENDING: `trig_valid` holds until `trig_ready`; further ticks cause no fires; `busy` goes to 0 the cycle after the transfer; `tick_cnt` is 0 when re-enabled, so `div`=2 fires on the 2nd tick.
- Reset asserted while PENDING with `overrun_count`=3: the next cycle shows all outputs 0 and state IDLE.
